pc_fetch_ctrl: RTL

- Sequences the program counter and instruction fetch for the multicycle MIPS core.
- Owns the PC register and issues one fetch at a time to instruction memory over a req/ack handshake.
- Holds the returned word for the decode stage until it is consumed.
- Applies branch and jump redirects, including redirects that arrive while a fetch is outstanding.

---
 rtl/pc_fetch_ctrl_if.sv | 21 ++
 rtl/pc_fetch_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch handshake between pc_fetch_ctrl (master) and imem (slave).
interface pc_fetch_ctrl_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and single-outstanding instruction fetch for the multicycle MIPS core.
// Optional exception redirect enabled by defining PC_FETCH_EXC_EN.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] PC_INC     = 32'd4,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  br_taken,
   input  logic [31:0]           br_target,
   input  logic                  jump,
   input  logic [31:0]           jump_target,
`ifdef PC_FETCH_EXC_EN
   input  logic                  exc,
   output logic [31:0]           epc,
`endif
   pc_fetch_ctrl_if.master       imem,
   output logic [31:0]           instr,
   output logic                  instr_valid,
   output logic [31:0]           instr_pc,
   output logic [31:0]           pc
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StFetch   = 2'd1,
      StDeliver = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        valid_q, valid_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;

   logic        exc_req;
   logic        redir;
   logic [31:0] redir_tgt;

`ifdef PC_FETCH_EXC_EN
   logic [31:0] epc_q, epc_d;
   assign exc_req = exc;
   assign epc     = epc_q;
`else
   assign exc_req = 1'b0;
`endif

   // Exception outranks branch, branch outranks jump; targets are word aligned.
   assign redir = exc_req | br_taken | jump;

   always_comb begin
      redir_tgt = jump_target;
      if (exc_req) begin
         redir_tgt = EXC_VECTOR;
      end else if (br_taken) begin
         redir_tgt = br_target;
      end
      redir_tgt = redir_tgt & ~32'h3;
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_d      = req_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      valid_d    = valid_q;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
`ifdef PC_FETCH_EXC_EN
      epc_d      = epc_q;
`endif

      case (state_q)
         StIdle: begin
            state_d = StFetch;
            req_d   = 1'b1;
         end

         StFetch: begin
            if (imem.imem_ack) begin
               if (redir) begin
                  pc_d   = redir_tgt;
                  pend_d = 1'b0;
               end else if (pend_q) begin
                  pc_d   = pend_tgt_q;
                  pend_d = 1'b0;
               end else begin
                  instr_d    = imem.imem_rdata;
                  instr_pc_d = pc_q;
                  valid_d    = 1'b1;
                  pc_d       = pc_q + PC_INC;
                  req_d      = 1'b0;
                  state_d    = StDeliver;
               end
            end else if (redir) begin
               // Request stays up; the redirect is applied once this fetch completes.
               pend_d     = 1'b1;
               pend_tgt_d = redir_tgt;
            end
`ifdef PC_FETCH_EXC_EN
            if (exc_req) begin
               epc_d = pc_q;
            end
`endif
         end

         StDeliver: begin
            if (redir) begin
               valid_d = 1'b0;
               pc_d    = redir_tgt;
               req_d   = 1'b1;
               state_d = StFetch;
`ifdef PC_FETCH_EXC_EN
               if (exc_req) begin
                  epc_d = instr_pc_q;
               end
`endif
            end else if (!stall) begin
               valid_d = 1'b0;
               req_d   = 1'b1;
               state_d = StFetch;
            end
         end

         default: begin
            state_d = StIdle;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         pc_q       <= RESET_PC;
         req_q      <= 1'b0;
         instr_q    <= 32'h0;
         instr_pc_q <= 32'h0;
         valid_q    <= 1'b0;
         pend_q     <= 1'b0;
         pend_tgt_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_q      <= req_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         valid_q    <= valid_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

`ifdef PC_FETCH_EXC_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         epc_q <= 32'h0;
      end else begin
         epc_q <= epc_d;
      end
   end
`endif

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign instr          = instr_q;
   assign instr_valid    = valid_q;
   assign instr_pc       = instr_pc_q;
   assign pc             = pc_q;

endmodule
